// File: rtl/sms4_lt_pipe.sv
// sms4_lt_pipe: pipelined SMS4 rotate/XOR engine (L, L', programmable rotate, identity).
// Define SMS4_LT_PIPE2_EN for a two-stage pipeline (capacity 2, latency 2).
module sms4_lt_pipe #(
  parameter int BWIDTH = 32,
  parameter int ROTW = 5,
  parameter int R1 = 2,
  parameter int R2 = 10,
  parameter int R3 = 18,
  parameter int R4 = 24,
  parameter int K1 = 13,
  parameter int K2 = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:BWIDTH-1] in_data,
  input  logic [1:0]        in_mode,
  input  logic [ROTW-1:0]   in_rot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:BWIDTH-1] out_data,
  output logic [1:0]        out_mode,
  output logic              busy
);
  function automatic logic [0:BWIDTH-1] rotl(input logic [0:BWIDTH-1] b, input int n);
    logic [0:2*BWIDTH-1] d;
    d = {b, b} << n;
    return d[0:BWIDTH-1];
  endfunction

  function automatic logic [0:BWIDTH-1] lt(input logic [0:BWIDTH-1] b, input logic [1:0] m, input int n);
    return m == 2'd0 ? b ^ rotl(b, R1 % BWIDTH) ^ rotl(b, R2 % BWIDTH) ^ rotl(b, R3 % BWIDTH) ^ rotl(b, R4 % BWIDTH) :
           m == 2'd1 ? b ^ rotl(b, K1 % BWIDTH) ^ rotl(b, K2 % BWIDTH) :
           m == 2'd2 ? rotl(b, n) : b;
  endfunction

  logic [ROTW-1:0] rot_m;
  logic            out_adv;
  assign rot_m = ROTW'(int'(in_rot) % BWIDTH);
  assign out_adv = !out_valid || out_ready;

`ifdef SMS4_LT_PIPE2_EN
  logic              a_valid;
  logic [0:BWIDTH-1] a_data;
  logic [1:0]        a_mode;
  logic [ROTW-1:0]   a_rot;
  logic              a_adv;
  assign a_adv = !a_valid || out_adv;
  assign in_ready = !rst && a_adv;
  assign busy = a_valid || out_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data <= '0;
      a_mode <= '0;
      a_rot <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_mode <= '0;
    end else begin
      if (a_adv) begin
        a_valid <= in_valid;
        if (in_valid) begin
          a_data <= in_data;
          a_mode <= in_mode;
          a_rot <= rot_m;
        end
      end
      if (out_adv) begin
        out_valid <= a_valid;
        if (a_valid) begin
          out_data <= lt(a_data, a_mode, int'(a_rot));
          out_mode <= a_mode;
        end
      end
    end
  end
`else
  assign in_ready = !rst && out_adv;
  assign busy = out_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_mode <= '0;
    end else if (out_adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= lt(in_data, in_mode, int'(rot_m));
        out_mode <= in_mode;
      end
    end
  end
`endif
endmodule
